// File: rtl/fp_mul_arbiter.sv
// Round-robin front end sharing one combinational FP32 multiplier across NUM_REQ requesters.
// Latency: accept -> ISSUE -> RESP (rsp_valid two edges after accept); response held until rsp_ready.
module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a_operand,
  input  logic [32*NUM_REQ-1:0]  req_b_operand,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            mul_a_operand,
  output logic [31:0]            mul_b_operand,
  input  logic [31:0]            mul_result,
  input  logic                   mul_exception,
  input  logic                   mul_overflow,
  input  logic                   mul_underflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic [2:0]             rsp_flags,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     last_grant_q;
  logic [ID_W-1:0]     id_q;
  logic [31:0]         mul_a_q;
  logic [31:0]         mul_b_q;
  logic [31:0]         result_q;
  logic [2:0]          flags_q;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     win_idx;
  logic                win_vld;
  logic [31:0]         sel_a;
  logic [31:0]         sel_b;
  int                  idx;

  // Scan starts one past the last winner and wraps, so the first valid hit is the RR choice.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    win_vld = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    idx     = 0;
    if (state_q == IDLE && !rst) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(last_grant_q) + k) % NUM_REQ;
        if (!win_vld && req_valid[idx]) begin
          win_vld    = 1'b1;
          grant[idx] = 1'b1;
          win_idx    = ID_W'(idx);
          sel_a      = req_a_operand[32*idx +: 32];
          sel_b      = req_b_operand[32*idx +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      result_q     <= '0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            mul_a_q      <= sel_a;
            mul_b_q      <= sel_b;
            id_q         <= win_idx;
            last_grant_q <= win_idx;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          result_q <= mul_result;
          flags_q  <= {mul_exception, mul_overflow, mul_underflow};
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = grant;
  assign mul_a_operand = mul_a_q;
  assign mul_b_operand = mul_b_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_id        = id_q;
  assign rsp_result    = result_q;
  assign rsp_flags     = flags_q;
  assign busy          = (state_q != IDLE);

endmodule
